arb4_rr: RTL and testbench

Four-requester round-robin arbiter that shares a single resource among four masters and drives a one-hot, 2-to-4-decoded grant vector. It sits in front of the shared unit: requesters raise `req`, the arbiter selects one and holds the grant until release or timeout, then rotates priority. The grant index is kept as a 2-bit register and decoded to one-hot with the same bit ordering as the team's 2:4 decoder: index 0 maps to `gnt[0]`, index 3 maps to `gnt[3]`.

---
 rtl/arb4_rr_if.sv | 20 ++
 rtl/arb4_rr.sv | 134 +++++++++++++
 tb/tb_arb4_rr.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arb4_rr_if.sv
// ---------------------------------------------------------------------------
// arb4_rr_if
// Handshake bundle between four requesters and the round-robin arbiter.
//   req      [0:3] request lines, one per requester (driven by masters)
//   gnt      [0:3] one-hot grant, all-zero when nobody holds the resource
//   gnt_idx  [1:0] index of the current or most recent grantee
//   busy           high while a grant is presented
//   timeout        one-cycle pulse when a grant is forcibly revoked
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface arb4_rr_if;
    logic [0:3] req;
    logic [0:3] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       timeout;

    modport master (output req, input gnt, input gnt_idx, input busy, input timeout);
    modport slave  (input req, output gnt, output gnt_idx, output busy, output timeout);
endinterface

// File: rtl/arb4_rr.sv
// ---------------------------------------------------------------------------
// arb4_rr
// Four-requester round-robin arbiter with optional hold timeout.
// A request seen in IDLE is granted, the grant is held until the grantee
// drops its request or MAX_HOLD cycles elapse, then priority rotates to the
// line after the grantee. Every grant is followed by at least one IDLE cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    arb4_rr_if.slave: req in; gnt, gnt_idx, busy, timeout out
// Parameter:
//   MAX_HOLD  maximum consecutive grant cycles (0 = no timeout)
// ---------------------------------------------------------------------------
module arb4_rr #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    arb4_rr_if.slave  bus
);

    localparam int unsigned CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       gnt_idx_q, gnt_idx_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

    // Output stage: every visible output is a flop fed only from state
    // registers, so the request lines never reach gnt combinationally.
    logic [0:3]       gnt_q, gnt_d;
    logic             busy_q;
    logic             to_evt;
    logic             to_evt_q;
    logic             timeout_q;

    logic [1:0]       sel_idx;
    logic             sel_vld;
    logic [1:0]       cand;

    // Rotating priority scan; walking offsets from 3 down to 0 lets the
    // lowest offset from ptr overwrite the others and win.
    always_comb begin
        sel_idx = ptr_q;
        sel_vld = 1'b0;
        cand    = ptr_q;
        for (int unsigned k = 4; k > 0; k--) begin
            cand = ptr_q + 2'(k - 1);
            if (bus.req[cand]) begin
                sel_idx = cand;
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_idx_d  = gnt_idx_q;
        hold_cnt_d = hold_cnt_q;
        to_evt     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    gnt_idx_d  = sel_idx;
                    hold_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                // Release is tested first so it wins over a coincident timeout.
                if (!bus.req[gnt_idx_q]) begin
                    state_d = IDLE;
                    ptr_d   = gnt_idx_q + 2'd1;
                end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST)) begin
                    state_d = IDLE;
                    ptr_d   = gnt_idx_q + 2'd1;
                    to_evt  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_d = '0;
        if (state_q == GRANT) begin
            gnt_d[gnt_idx_q] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_idx_q  <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    // gnt/busy lag the state register by one edge, so the revocation event
    // is delayed one extra stage to line timeout up with the first gnt=0 cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            to_evt_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            gnt_q     <= gnt_d;
            busy_q    <= (state_q == GRANT);
            to_evt_q  <= to_evt;
            timeout_q <= to_evt_q;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = gnt_idx_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_arb4_rr.sv
// ---------------------------------------------------------------------------
// tb_arb4_rr
// Self-checking bench for arb4_rr with MAX_HOLD=4. Each scenario task pushes
// the grant vectors it expects onto a queue; a monitor pops one entry at the
// start of every grant and compares. Timing details are checked inline.
// ---------------------------------------------------------------------------
module tb_arb4_rr;

    logic clk = 1'b0;
    logic rst_n;

    arb4_rr_if bus();

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [0:3] exp_q[$];

    always #5 clk = ~clk;

    arb4_rr #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Grant-order scoreboard: compare at the first cycle of each grant.
    initial begin : monitor
        logic [0:3] prev_gnt;
        logic [0:3] exp;
        prev_gnt = '0;
        forever begin
            @(negedge clk);
            if (bus.gnt != 4'b0000 && prev_gnt == 4'b0000) begin
                total_cnt++;
                if (exp_q.size() == 0) begin
                    $display("FAIL grant_order: got gnt=%b, required no grant", bus.gnt);
                end else begin
                    exp = exp_q.pop_front();
                    if (bus.gnt !== exp)
                        $display("FAIL grant_order: got gnt=%b, required %b", bus.gnt, exp);
                    else
                        pass_cnt++;
                end
            end
            prev_gnt = bus.gnt;
        end
    end

    task automatic wait_grant(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.gnt != 4'b0000) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total_cnt++;
            $display("FAIL %s: got no grant within 50 cycles, required a grant", name);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.gnt == 4'b0000) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total_cnt++;
            $display("FAIL %s: gnt=%b still set after 50 cycles, required 0000", name, bus.gnt);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        bus.req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        bus.req = 4'b1111;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (bus.gnt !== 4'b0000) $display("FAIL reset_gnt: got %b, required 0000", bus.gnt);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", bus.busy);
        else pass_cnt++;
        total_cnt++;
        if (bus.timeout !== 1'b0) $display("FAIL reset_timeout: got %b, required 0", bus.timeout);
        else pass_cnt++;
        total_cnt++;
        if (bus.gnt_idx !== 2'd0) $display("FAIL reset_gnt_idx: got %0d, required 0", bus.gnt_idx);
        else pass_cnt++;

        exp_q.push_back(4'b1000);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.gnt !== 4'b0000) $display("FAIL first_grant_edge1: got %b, required 0000", bus.gnt);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (bus.gnt !== 4'b1000) $display("FAIL first_grant_edge2: got %b, required 1000", bus.gnt);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b1) $display("FAIL first_grant_busy: got %b, required 1", bus.busy);
        else pass_cnt++;
        total_cnt++;
        if (bus.gnt_idx !== 2'd0) $display("FAIL first_grant_idx: got %0d, required 0", bus.gnt_idx);
        else pass_cnt++;
        bus.req = '0;
        @(negedge clk);
        wait_idle("reset_release");
    endtask

    task automatic test_fairness();
        bit ok;
        int idx;
        int zeros;
        do_reset();
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0010);
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b1000);
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant("fair_grant", ok);
            if (!ok) break;
            idx = 0;
            for (int b = 0; b < 4; b++) if (bus.gnt[b]) idx = b;
            if (k == 4) begin
                bus.req = '0;
                break;
            end
            bus.req[idx] = 1'b0;
            wait_idle("fair_release");
            bus.req[idx] = 1'b1;
            zeros = 0;
            for (int i = 0; i < 20 && bus.gnt == 4'b0000; i++) begin
                zeros++;
                @(negedge clk);
            end
            total_cnt++;
            if (zeros !== 1) $display("FAIL fair_gap: got %0d idle cycles, required 1", zeros);
            else pass_cnt++;
        end
        wait_idle("fair_end");
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        exp_q.push_back(4'b0010);
        bus.req = 4'b0010;
        wait_grant("wrap_idx2", ok);
        bus.req = '0;
        wait_idle("wrap_idx2_release");
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b1000);
        bus.req = 4'b1001;
        wait_grant("wrap_idx3", ok);
        total_cnt++;
        if (bus.gnt_idx !== 2'd3) $display("FAIL wrap_gnt_idx: got %0d, required 3", bus.gnt_idx);
        else pass_cnt++;
        bus.req = 4'b1000;
        wait_idle("wrap_idx3_release");
        wait_grant("wrap_idx0", ok);
        bus.req = '0;
        wait_idle("wrap_end");
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt;
        exp_q.push_back(4'b0100);
        exp_q.push_back(4'b0100);
        bus.req = 4'b0100;
        wait_grant("to_grant", ok);
        cnt = 0;
        for (int i = 0; i < 20 && bus.gnt == 4'b0100; i++) begin
            cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (cnt !== 4) $display("FAIL to_hold_len: got %0d cycles, required 4", cnt);
        else pass_cnt++;
        total_cnt++;
        if (bus.timeout !== 1'b1) $display("FAIL to_pulse: got %b, required 1", bus.timeout);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.timeout !== 1'b0) $display("FAIL to_pulse_end: got %b, required 0", bus.timeout);
        else pass_cnt++;
        bus.req = '0;
        wait_idle("to_end");
    endtask

    task automatic test_coincide();
        bit ok;
        int cnt;
        exp_q.push_back(4'b0100);
        bus.req = 4'b0100;
        wait_grant("co_grant", ok);
        cnt = 0;
        for (int i = 0; i < 20 && bus.gnt == 4'b0100; i++) begin
            cnt++;
            if (cnt == 3) bus.req = '0;
            @(negedge clk);
        end
        total_cnt++;
        if (cnt !== 4) $display("FAIL co_hold_len: got %0d cycles, required 4", cnt);
        else pass_cnt++;
        total_cnt++;
        if (bus.timeout !== 1'b0) $display("FAIL co_timeout: got %b, required 0", bus.timeout);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bus.timeout !== 1'b0 || bus.gnt !== 4'b0000)
            $display("FAIL co_after: got timeout=%b gnt=%b, required 0 0000", bus.timeout, bus.gnt);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        bit ok;
        // Park ptr at 3 so a ptr that survives reset would pick index 3.
        exp_q.push_back(4'b0010);
        bus.req = 4'b0010;
        wait_grant("ar_pre", ok);
        bus.req = '0;
        wait_idle("ar_pre_release");
        exp_q.push_back(4'b0010);
        bus.req = 4'b0010;
        wait_grant("ar_grant", ok);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.gnt !== 4'b0000) $display("FAIL ar_gnt_drop: got %b, required 0000", bus.gnt);
        else pass_cnt++;
        total_cnt++;
        if (bus.busy !== 1'b0) $display("FAIL ar_busy_drop: got %b, required 0", bus.busy);
        else pass_cnt++;
        exp_q.push_back(4'b0010);
        bus.req = 4'b0011;
        @(negedge clk);
        rst_n = 1'b1;
        wait_grant("ar_regrant", ok);
        total_cnt++;
        if (bus.gnt_idx !== 2'd2) $display("FAIL ar_gnt_idx: got %0d, required 2", bus.gnt_idx);
        else pass_cnt++;
        bus.req = '0;
        wait_idle("ar_end");
    endtask

    initial begin
        rst_n   = 1'b0;
        bus.req = '0;
        test_reset();
        test_fairness();
        test_wrap();
        test_timeout();
        test_coincide();
        test_async_reset();
        repeat (3) @(negedge clk);
        total_cnt++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
